// File: rtl/elevator_dispatcher_pkg.sv
// Shared constants and direction encoding for the elevator request dispatcher.
package elevator_dispatcher_pkg;
    localparam int FLOORS  = 8;
    localparam int FLOOR_W = 3;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;
endpackage

// File: rtl/elevator_dispatcher_if.sv
// Request inputs from the button processor and status outputs to the motion/door FSM.
interface elevator_dispatcher_if;
    import elevator_dispatcher_pkg::*;

    logic [FLOORS-1:0]  up_req;
    logic [FLOORS-1:0]  down_req;
    logic [FLOORS-1:0]  car_req;
    logic [FLOOR_W-1:0] floor;
    logic               moving;
    logic               arrived;
    logic [FLOORS-1:0]  up_pend;
    logic [FLOORS-1:0]  down_pend;
    logic [FLOORS-1:0]  car_pend;
    logic [1:0]         dir;
    logic               nextup;
    logic               nextdown;
    logic               stop_here;
    logic [FLOOR_W-1:0] target;
    logic               target_valid;

    modport master (
        output up_req, down_req, car_req, floor, moving, arrived,
        input  up_pend, down_pend, car_pend, dir, nextup, nextdown,
               stop_here, target, target_valid
    );

    modport slave (
        input  up_req, down_req, car_req, floor, moving, arrived,
        output up_pend, down_pend, car_pend, dir, nextup, nextdown,
               stop_here, target, target_valid
    );
endinterface

// File: rtl/elevator_dispatcher_pri_enc.sv
// Masked priority encoder: nearest set bit strictly above and strictly below an index.
module floor_pri_enc
    import elevator_dispatcher_pkg::*;
(
    input  logic [FLOORS-1:0]  i_vec,
    input  logic [FLOOR_W-1:0] i_idx,
    output logic [FLOOR_W-1:0] o_lo_above,
    output logic               o_any_above,
    output logic [FLOOR_W-1:0] o_hi_below,
    output logic               o_any_below
);
    always_comb begin
        o_lo_above  = '0;
        o_any_above = 1'b0;
        o_hi_below  = '0;
        o_any_below = 1'b0;
        // Downward scan: the last hit above the index is the lowest one.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (i_vec[i] && (FLOOR_W'(i) > i_idx)) begin
                o_lo_above  = FLOOR_W'(i);
                o_any_above = 1'b1;
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (i_vec[i] && (FLOOR_W'(i) < i_idx)) begin
                o_hi_below  = FLOOR_W'(i);
                o_any_below = 1'b1;
            end
        end
    end
endmodule

// File: rtl/elevator_dispatcher.sv
// LOOK request scheduler: latches hall/car requests, picks travel direction,
// flags stops and clears requests as they are served.
module elevator_dispatcher
    import elevator_dispatcher_pkg::*;
(
    input  logic clk,
    input  logic rst,
    elevator_dispatcher_if.slave bus
);
    localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [FLOORS-1:0]  r_up, r_dn, r_car;
    dir_t               r_dir;
    logic               r_nextup, r_nextdown, r_tvalid, r_stop;
    logic [FLOOR_W-1:0] r_target;

    logic [FLOORS-1:0]  w_any_pend, w_any_eff;
    logic [FLOORS-1:0]  w_up_clr, w_dn_clr, w_car_clr;
    logic [FLOORS-1:0]  w_up_eff, w_dn_eff, w_car_eff;
    logic [FLOOR_W-1:0] w_svc_lo, w_svc_hi, w_dir_lo, w_dir_hi;
    logic               w_svc_above, w_svc_below, w_above, w_below;
    dir_t               w_dir_nxt;
    logic               w_stop_nxt;
    logic [FLOOR_W-1:0] w_target_nxt;

    assign w_any_pend = r_up | r_dn | r_car;

    // Pre-clear view: decides which hall calls the arrival serves; also yields target.
    floor_pri_enc u_enc_svc (
        .i_vec       (w_any_pend),
        .i_idx       (bus.floor),
        .o_lo_above  (w_svc_lo),
        .o_any_above (w_svc_above),
        .o_hi_below  (w_svc_hi),
        .o_any_below (w_svc_below)
    );

    always_comb begin
        w_up_clr  = '0;
        w_dn_clr  = '0;
        w_car_clr = '0;
        if (bus.arrived) begin
            w_car_clr[bus.floor] = 1'b1;
            case (r_dir)
                DIR_UP: begin
                    w_up_clr[bus.floor] = 1'b1;
                    w_dn_clr[bus.floor] = !w_svc_above;
                end
                DIR_DOWN: begin
                    w_dn_clr[bus.floor] = 1'b1;
                    w_up_clr[bus.floor] = !w_svc_below;
                end
                default: begin
                    w_up_clr[bus.floor] = 1'b1;
                    w_dn_clr[bus.floor] = 1'b1;
                end
            endcase
        end
    end

    assign w_up_eff  = r_up  & ~w_up_clr;
    assign w_dn_eff  = r_dn  & ~w_dn_clr;
    assign w_car_eff = r_car & ~w_car_clr;
    assign w_any_eff = w_up_eff | w_dn_eff | w_car_eff;

    floor_pri_enc u_enc_dir (
        .i_vec       (w_any_eff),
        .i_idx       (bus.floor),
        .o_lo_above  (w_dir_lo),
        .o_any_above (w_above),
        .o_hi_below  (w_dir_hi),
        .o_any_below (w_below)
    );

    always_comb begin
        w_dir_nxt = r_dir;
        if (!bus.moving) begin
            case (r_dir)
                DIR_UP:   w_dir_nxt = w_above ? DIR_UP   : (w_below ? DIR_DOWN : DIR_IDLE);
                DIR_DOWN: w_dir_nxt = w_below ? DIR_DOWN : (w_above ? DIR_UP   : DIR_IDLE);
                default: begin
                    // Both sides pending: nearer floor wins, ties go up.
                    if (w_above && w_below)
                        w_dir_nxt = ((w_dir_lo - bus.floor) <= (bus.floor - w_dir_hi))
                                    ? DIR_UP : DIR_DOWN;
                    else if (w_above)
                        w_dir_nxt = DIR_UP;
                    else if (w_below)
                        w_dir_nxt = DIR_DOWN;
                    else
                        w_dir_nxt = DIR_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_stop_nxt = w_car_eff[bus.floor];
        case (w_dir_nxt)
            DIR_UP:   w_stop_nxt = w_stop_nxt | w_up_eff[bus.floor]
                                   | (!w_above && w_dn_eff[bus.floor]);
            DIR_DOWN: w_stop_nxt = w_stop_nxt | w_dn_eff[bus.floor]
                                   | (!w_below && w_up_eff[bus.floor]);
            default:  w_stop_nxt = w_stop_nxt | w_any_eff[bus.floor];
        endcase
        case (w_dir_nxt)
            DIR_UP:   w_target_nxt = w_svc_lo;
            DIR_DOWN: w_target_nxt = w_svc_hi;
            default:  w_target_nxt = bus.floor;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_up       <= '0;
            r_dn       <= '0;
            r_car      <= '0;
            r_dir      <= DIR_IDLE;
            r_nextup   <= 1'b0;
            r_nextdown <= 1'b0;
            r_tvalid   <= 1'b0;
            r_stop     <= 1'b0;
            r_target   <= '0;
        end else begin
            // Clear beats a same-cycle set: the doors are already opening here.
            r_up       <= (r_up  | (bus.up_req   & UP_MASK)) & ~w_up_clr;
            r_dn       <= (r_dn  | (bus.down_req & DN_MASK)) & ~w_dn_clr;
            r_car      <= (r_car | bus.car_req) & ~w_car_clr;
            r_dir      <= w_dir_nxt;
            r_nextup   <= (w_dir_nxt == DIR_UP);
            r_nextdown <= (w_dir_nxt == DIR_DOWN);
            r_tvalid   <= (w_dir_nxt != DIR_IDLE);
            r_stop     <= w_stop_nxt;
            r_target   <= w_target_nxt;
        end
    end

    assign bus.up_pend      = r_up;
    assign bus.down_pend    = r_dn;
    assign bus.car_pend     = r_car;
    assign bus.dir          = r_dir;
    assign bus.nextup       = r_nextup;
    assign bus.nextdown     = r_nextdown;
    assign bus.target_valid = r_tvalid;
    assign bus.stop_here    = r_stop;
    assign bus.target       = r_target;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher: expectations queued with each stimulus
// step and checked one clock later.
module tb_elevator_dispatcher;
    import elevator_dispatcher_pkg::*;

    localparam int S_UP = 0, S_DN = 1, S_CAR = 2, S_DIR = 3, S_NUP = 4,
                   S_NDN = 5, S_STOP = 6, S_TGT = 7, S_TV = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    elevator_dispatcher_if bus();

    elevator_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_UP:    return 32'(bus.up_pend);
            S_DN:    return 32'(bus.down_pend);
            S_CAR:   return 32'(bus.car_pend);
            S_DIR:   return 32'(bus.dir);
            S_NUP:   return 32'(bus.nextup);
            S_NDN:   return 32'(bus.nextdown);
            S_STOP:  return 32'(bus.stop_here);
            S_TGT:   return 32'(bus.target);
            default: return 32'(bus.target_valid);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_idle_all(input string tag);
        expect_out({tag, "_up"},   S_UP,   0);
        expect_out({tag, "_dn"},   S_DN,   0);
        expect_out({tag, "_car"},  S_CAR,  0);
        expect_out({tag, "_dir"},  S_DIR,  DIR_IDLE);
        expect_out({tag, "_stop"}, S_STOP, 0);
        expect_out({tag, "_tv"},   S_TV,   0);
        expect_out({tag, "_nup"},  S_NUP,  0);
        expect_out({tag, "_ndn"},  S_NDN,  0);
    endtask

    // One clock, then compare everything queued for this step.
    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp)
            else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic clear_reqs();
        bus.up_req   = '0;
        bus.down_req = '0;
        bus.car_req  = '0;
        bus.arrived  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clear_reqs();
        bus.floor   = '0;
        bus.moving  = 1'b0;

        step();
        expect_idle_all("reset");
        expect_out("reset_tgt", S_TGT, 0);
        step();
        rst = 1'b1;
        expect_idle_all("run_idle");
        step();

        // Single car call above.
        bus.floor   = 3'd0;
        bus.car_req = 8'h10;
        expect_out("car_latch", S_CAR, 8'h10);
        expect_out("car_latch_dir", S_DIR, DIR_IDLE);
        step();
        clear_reqs();
        expect_out("car_dir_up", S_DIR, DIR_UP);
        expect_out("car_tgt4", S_TGT, 4);
        expect_out("car_nup", S_NUP, 1);
        expect_out("car_tv", S_TV, 1);
        step();
        bus.floor   = 3'd4;
        bus.arrived = 1'b1;
        expect_out("car_served", S_CAR, 0);
        expect_out("car_served_dir", S_DIR, DIR_IDLE);
        expect_out("car_served_nup", S_NUP, 0);
        expect_out("car_served_tv", S_TV, 0);
        expect_out("car_served_tgt", S_TGT, 4);
        step();
        clear_reqs();

        // Equidistant calls from floor 3: tie goes up.
        bus.floor    = 3'd3;
        bus.up_req   = 8'h20;
        bus.down_req = 8'h02;
        expect_out("tie_up_pend", S_UP, 8'h20);
        expect_out("tie_dn_pend", S_DN, 8'h02);
        expect_out("tie_dir_idle", S_DIR, DIR_IDLE);
        step();
        clear_reqs();
        expect_out("tie_dir_up", S_DIR, DIR_UP);
        expect_out("tie_tgt5", S_TGT, 5);
        step();
        bus.floor   = 3'd5;
        bus.arrived = 1'b1;
        expect_out("tie_up_cleared", S_UP, 0);
        expect_out("tie_dn_kept", S_DN, 8'h02);
        expect_out("tie_dir_down", S_DIR, DIR_DOWN);
        expect_out("tie_tgt1", S_TGT, 1);
        expect_out("tie_ndn", S_NDN, 1);
        expect_out("tie_stop5", S_STOP, 0);
        step();
        bus.floor   = 3'd1;
        expect_out("bottom_dn_cleared", S_DN, 0);
        expect_out("bottom_dir_idle", S_DIR, DIR_IDLE);
        step();
        clear_reqs();

        // Down call passed while going up, served on the way back.
        bus.floor    = 3'd2;
        bus.car_req  = 8'h40;
        bus.down_req = 8'h04;
        expect_out("pass_car", S_CAR, 8'h40);
        expect_out("pass_dn", S_DN, 8'h04);
        step();
        clear_reqs();
        expect_out("pass_dir_up", S_DIR, DIR_UP);
        expect_out("pass_stop2", S_STOP, 0);
        expect_out("pass_tgt6", S_TGT, 6);
        step();
        bus.floor   = 3'd6;
        bus.arrived = 1'b1;
        expect_out("pass_car_clr", S_CAR, 0);
        expect_out("pass_dn_kept", S_DN, 8'h04);
        expect_out("pass_dir_down", S_DIR, DIR_DOWN);
        expect_out("pass_tgt2", S_TGT, 2);
        step();
        clear_reqs();
        bus.moving = 1'b1;
        bus.floor  = 3'd2;
        expect_out("back_dir_down", S_DIR, DIR_DOWN);
        expect_out("back_stop2", S_STOP, 1);
        step();
        bus.moving  = 1'b0;
        bus.arrived = 1'b1;
        expect_out("back_dn_clr", S_DN, 0);
        expect_out("back_dir_idle", S_DIR, DIR_IDLE);
        expect_out("back_stop_clr", S_STOP, 0);
        step();
        clear_reqs();

        // Direction frozen while moving.
        bus.floor   = 3'd1;
        bus.car_req = 8'h20;
        expect_out("frz_car", S_CAR, 8'h20);
        step();
        clear_reqs();
        expect_out("frz_dir_up", S_DIR, DIR_UP);
        expect_out("frz_tgt5", S_TGT, 5);
        step();
        bus.moving  = 1'b1;
        bus.floor   = 3'd5;
        bus.car_req = 8'h04;
        expect_out("frz_car2", S_CAR, 8'h24);
        expect_out("frz_hold1", S_DIR, DIR_UP);
        step();
        clear_reqs();
        expect_out("frz_hold2", S_DIR, DIR_UP);
        step();
        bus.moving = 1'b0;
        expect_out("frz_rev_down", S_DIR, DIR_DOWN);
        expect_out("frz_stop5", S_STOP, 1);
        expect_out("frz_tgt2", S_TGT, 2);
        step();
        bus.arrived = 1'b1;
        expect_out("frz_car5_clr", S_CAR, 8'h04);
        expect_out("frz_keep_down", S_DIR, DIR_DOWN);
        step();
        clear_reqs();

        // Arrival and press at the same floor in one cycle.
        bus.floor   = 3'd4;
        bus.arrived = 1'b1;
        bus.car_req = 8'h10;
        expect_out("clr_wins_car", S_CAR, 8'h04);
        expect_out("clr_wins_dir", S_DIR, DIR_DOWN);
        step();
        clear_reqs();
        bus.moving = 1'b1;
        bus.up_req = 8'h08;
        expect_out("mid_up_pend", S_UP, 8'h08);
        step();
        clear_reqs();
        rst = 1'b0;
        expect_idle_all("mid_rst");
        expect_out("mid_rst_tgt", S_TGT, 0);
        step();
        rst = 1'b1;

        // Non-existent buttons at the shaft ends.
        bus.moving   = 1'b0;
        bus.up_req   = 8'h80;
        bus.down_req = 8'h01;
        expect_out("nobtn_up7", S_UP, 0);
        expect_out("nobtn_dn0", S_DN, 0);
        step();
        clear_reqs();
        expect_out("nobtn_dir", S_DIR, DIR_IDLE);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
